fixed_att_weight_scheduler: RTL and testbench

Sequences a single shared weight stream into the three projection weight ports (q, k, v) of the fixed-point attention datapath. The stream arrives from a weight loader as ordered tiles: all Q tiles for one pass, then all K tiles, then all V tiles, with the whole group repeated once per input row block. The block routes each tile to the correct projection through a one-entry registered stage. It exposes start/busy/done so a top-level controller can launch and track one full weight load.

---
 rtl/fixed_att_weight_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_fixed_att_weight_scheduler.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_att_weight_scheduler.sv
// -----------------------------------------------------------------------------
// fixed_att_weight_scheduler
//
// Routes one shared weight-tile stream into the Q, K and V projection weight
// ports of the fixed-point attention datapath. A full load is
// IN_NUM_PARALLELISM passes. Each pass carries TILES_PER_PROJ Q tiles, then
// TILES_PER_PROJ K tiles, then TILES_PER_PROJ V tiles. Each tile passes
// through a single registered stage. The registered stage is fanned out to all
// three destinations, and only the valid of the routed destination is raised.
//
// Ports
//   clk, rst                : clock, asynchronous active-low reset
//   start                   : one-cycle launch pulse (honoured only when idle)
//   busy                    : high while a load is in progress
//   done                    : one-cycle pulse after the last tile has drained
//   weight_in/_valid/_ready : shared input tile stream
//   weight_{q,k,v}          : registered tile (same register on all three)
//   weight_{q,k,v}_valid    : per-destination valid
//   weight_{q,k,v}_ready    : per-destination ready
// -----------------------------------------------------------------------------
module fixed_att_weight_scheduler #(
  parameter int WEIGHT_WIDTH       = 8,
  parameter int W_PARALLELISM      = 3,
  parameter int W_SIZE             = 3,
  parameter int W_NUM_PARALLELISM  = 2,
  parameter int IN_DEPTH           = 3,
  parameter int IN_NUM_PARALLELISM = 2
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 start,
  output logic                                                 busy,
  output logic                                                 done,
  input  logic [W_PARALLELISM*W_SIZE-1:0][WEIGHT_WIDTH-1:0]    weight_in,
  input  logic                                                 weight_in_valid,
  output logic                                                 weight_in_ready,
  output logic [W_PARALLELISM*W_SIZE-1:0][WEIGHT_WIDTH-1:0]    weight_q,
  output logic [W_PARALLELISM*W_SIZE-1:0][WEIGHT_WIDTH-1:0]    weight_k,
  output logic [W_PARALLELISM*W_SIZE-1:0][WEIGHT_WIDTH-1:0]    weight_v,
  output logic                                                 weight_q_valid,
  output logic                                                 weight_k_valid,
  output logic                                                 weight_v_valid,
  input  logic                                                 weight_q_ready,
  input  logic                                                 weight_k_ready,
  input  logic                                                 weight_v_ready
);

  localparam int TILES_PER_PROJ = W_NUM_PARALLELISM * IN_DEPTH;
  localparam int TILE_ELEMS     = W_PARALLELISM * W_SIZE;
  localparam int TC_W = (TILES_PER_PROJ > 1) ? $clog2(TILES_PER_PROJ) : 1;
  localparam int RC_W = (IN_NUM_PARALLELISM > 1) ? $clog2(IN_NUM_PARALLELISM) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEND_Q = 3'd1,
    SEND_K = 3'd2,
    SEND_V = 3'd3,
    DRAIN  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    DST_Q = 2'd0,
    DST_K = 2'd1,
    DST_V = 2'd2
  } dest_t;

  state_t state_q, state_d;

  logic [TC_W-1:0] tile_cnt;
  logic [RC_W-1:0] round_cnt;

  logic [TILE_ELEMS-1:0][WEIGHT_WIDTH-1:0] data_p0;
  dest_t                                   dest_p0;
  logic                                    vld_p0;

  logic  is_send;
  dest_t cur_dest;
  logic  dst_ready;
  logic  in_ready;
  logic  in_hs;
  logic  out_hs;
  logic  last_tile;
  logic  last_round;
  logic  drain_done;

  // Handshake decode. The ready looked at is that of the destination the
  // register currently holds, not that of the phase being accepted. This
  // lets the last tile of a phase drain to its own port after the FSM has
  // already advanced.
  always_comb begin
    is_send = (state_q == SEND_Q) || (state_q == SEND_K) || (state_q == SEND_V);
    case (state_q)
      SEND_K:  cur_dest = DST_K;
      SEND_V:  cur_dest = DST_V;
      default: cur_dest = DST_Q;
    endcase
    case (dest_p0)
      DST_K:   dst_ready = weight_k_ready;
      DST_V:   dst_ready = weight_v_ready;
      default: dst_ready = weight_q_ready;
    endcase
    in_ready   = is_send && (!vld_p0 || dst_ready);
    in_hs      = weight_in_valid && in_ready;
    out_hs     = vld_p0 && dst_ready;
    last_tile  = (tile_cnt == TC_W'(TILES_PER_PROJ - 1));
    last_round = (round_cnt == RC_W'(IN_NUM_PARALLELISM - 1));
    drain_done = (state_q == DRAIN) && (!vld_p0 || out_hs);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SEND_Q;
      SEND_Q:  if (in_hs && last_tile) state_d = SEND_K;
      SEND_K:  if (in_hs && last_tile) state_d = SEND_V;
      SEND_V:  if (in_hs && last_tile) state_d = last_round ? DRAIN : SEND_Q;
      DRAIN:   if (drain_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy            = (state_q != IDLE);
    weight_in_ready = in_ready;
    weight_q_valid  = vld_p0 && (dest_p0 == DST_Q);
    weight_k_valid  = vld_p0 && (dest_p0 == DST_K);
    weight_v_valid  = vld_p0 && (dest_p0 == DST_V);
    weight_q        = data_p0;
    weight_k        = data_p0;
    weight_v        = data_p0;
  end

  // Tile / round counters and the registered done pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tile_cnt  <= '0;
      round_cnt <= '0;
      done      <= 1'b0;
    end else begin
      done <= drain_done;
      if (state_q == IDLE) begin
        tile_cnt  <= '0;
        round_cnt <= '0;
      end else if (in_hs) begin
        tile_cnt <= last_tile ? '0 : tile_cnt + TC_W'(1);
        if (last_tile && (state_q == SEND_V)) begin
          round_cnt <= last_round ? '0 : round_cnt + RC_W'(1);
        end
      end
    end
  end

  // Stage p0: one-entry output register. A new tile may replace the held one
  // in the same cycle it is consumed, which sustains one tile per cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_p0 <= '0;
      dest_p0 <= DST_Q;
      vld_p0  <= 1'b0;
    end else begin
      if (in_hs) begin
        data_p0 <= weight_in;
        dest_p0 <= cur_dest;
        vld_p0  <= 1'b1;
      end else if (out_hs) begin
        vld_p0 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fixed_att_weight_scheduler.sv
module tb_fixed_att_weight_scheduler;

  localparam int WW   = 8;
  localparam int NE   = 9;   // W_PARALLELISM * W_SIZE
  localparam int TPP  = 6;   // tiles per projection per pass
  localparam int NT   = 36;  // tiles in one full load

  typedef logic [NE-1:0][WW-1:0] tile_t;

  logic  clk;
  logic  rst;
  logic  start;
  logic  busy;
  logic  done;
  tile_t weight_in;
  logic  weight_in_valid;
  logic  weight_in_ready;
  tile_t weight_q, weight_k, weight_v;
  logic  weight_q_valid, weight_k_valid, weight_v_valid;
  logic  weight_q_ready, weight_k_ready, weight_v_ready;

  fixed_att_weight_scheduler #(
    .WEIGHT_WIDTH       (8),
    .W_PARALLELISM      (3),
    .W_SIZE             (3),
    .W_NUM_PARALLELISM  (2),
    .IN_DEPTH           (3),
    .IN_NUM_PARALLELISM (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .busy            (busy),
    .done            (done),
    .weight_in       (weight_in),
    .weight_in_valid (weight_in_valid),
    .weight_in_ready (weight_in_ready),
    .weight_q        (weight_q),
    .weight_k        (weight_k),
    .weight_v        (weight_v),
    .weight_q_valid  (weight_q_valid),
    .weight_k_valid  (weight_k_valid),
    .weight_v_valid  (weight_v_valid),
    .weight_q_ready  (weight_q_ready),
    .weight_k_ready  (weight_k_ready),
    .weight_v_ready  (weight_v_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // scoreboard state
  bit sb_en    = 0;
  int sb_next  = 1;
  int done_cnt = 0;

  typedef struct {
    logic start;
    logic iv;
    int   val;
    logic rq, rk, rv;
    logic e_rdy, e_busy, e_done, e_qv, e_kv, e_vv;
    int   e_val;
  } vec_t;

  vec_t tbl[40];

  function automatic tile_t mk(input int n);
    tile_t t;
    for (int i = 0; i < NE; i++) t[i] = 8'(n);
    return t;
  endfunction

  // Tile n (1-based) goes to Q, K, V in blocks of TPP, repeating per pass.
  function automatic int dest_of(input int n);
    return ((n - 1) / TPP) % 3;
  endfunction

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic push(input int n, input bit rnd, input int budget);
    bit acc;
    acc = 0;
    weight_in       = mk(n);
    weight_in_valid = 1'b1;
    for (int k = 0; k < budget && !acc; k++) begin
      if (rnd) begin
        weight_q_ready = 1'($urandom_range(0, 1));
        weight_k_ready = 1'($urandom_range(0, 1));
        weight_v_ready = 1'($urandom_range(0, 1));
      end
      #1;
      if (weight_in_ready) acc = 1;
      step();
    end
    weight_in_valid = 1'b0;
    chk($sformatf("push_accept_%0d", n), 72'(acc), 72'(1));
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 0;
    weight_in_valid = 1'b0;
    weight_q_ready  = 1'b1;
    weight_k_ready  = 1'b1;
    weight_v_ready  = 1'b1;
    for (int k = 0; k < budget && !seen; k++) begin
      #1;
      if (done) seen = 1;
      step();
    end
    chk("done_seen", 72'(seen), 72'(1));
  endtask

  // Output monitor: every output handshake must deliver the next tile in
  // order, to the destination its position in the stream dictates.
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (sb_en) begin
      chk("valid_onehot",
          72'($countones({weight_q_valid, weight_k_valid, weight_v_valid}) <= 1), 72'(1));
      if (weight_q_valid && weight_q_ready) begin
        chk("sb_q_data", weight_q, mk(sb_next));
        chk("sb_q_dest", 72'(0), 72'(dest_of(sb_next)));
        sb_next++;
      end
      if (weight_k_valid && weight_k_ready) begin
        chk("sb_k_data", weight_k, mk(sb_next));
        chk("sb_k_dest", 72'(1), 72'(dest_of(sb_next)));
        sb_next++;
      end
      if (weight_v_valid && weight_v_ready) begin
        chk("sb_v_data", weight_v, mk(sb_next));
        chk("sb_v_dest", 72'(2), 72'(dest_of(sb_next)));
        sb_next++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // cycle-accurate table for one full load with all readies high
    for (int r = 0; r < 40; r++) begin
      tbl[r] = '{start: 1'b0, iv: 1'b0, val: 0, rq: 1'b1, rk: 1'b1, rv: 1'b1,
                 e_rdy: 1'b0, e_busy: 1'b0, e_done: 1'b0,
                 e_qv: 1'b0, e_kv: 1'b0, e_vv: 1'b0, e_val: 0};
      if (r == 0) tbl[r].start = 1'b1;
      if (r >= 1 && r <= NT) begin
        tbl[r].iv     = 1'b1;
        tbl[r].val    = r;
        tbl[r].e_rdy  = 1'b1;
        tbl[r].e_busy = 1'b1;
        if (r >= 2) begin
          tbl[r].e_val = r - 1;
          case (dest_of(r - 1))
            0:       tbl[r].e_qv = 1'b1;
            1:       tbl[r].e_kv = 1'b1;
            default: tbl[r].e_vv = 1'b1;
          endcase
        end
      end
      if (r == NT + 1) begin
        tbl[r].e_busy = 1'b1;
        tbl[r].e_vv   = 1'b1;
        tbl[r].e_val  = NT;
      end
      if (r == NT + 2) tbl[r].e_done = 1'b1;
    end

    rst             = 1'b0;
    start           = 1'b0;
    weight_in       = '0;
    weight_in_valid = 1'b0;
    weight_q_ready  = 1'b1;
    weight_k_ready  = 1'b1;
    weight_v_ready  = 1'b1;

    // reset state
    #3;
    chk("rst_busy", 72'(busy), 72'(0));
    chk("rst_done", 72'(done), 72'(0));
    chk("rst_in_ready", 72'(weight_in_ready), 72'(0));
    chk("rst_valids", 72'({weight_q_valid, weight_k_valid, weight_v_valid}), 72'(0));
    chk("rst_data", weight_q, '0);
    step();
    rst = 1'b1;
    step();

    // table-driven full load
    for (int r = 0; r < 40; r++) begin
      start           = tbl[r].start;
      weight_in_valid = tbl[r].iv;
      weight_in       = mk(tbl[r].val);
      weight_q_ready  = tbl[r].rq;
      weight_k_ready  = tbl[r].rk;
      weight_v_ready  = tbl[r].rv;
      #3;
      chk($sformatf("t%0d_in_ready", r), 72'(weight_in_ready), 72'(tbl[r].e_rdy));
      chk($sformatf("t%0d_busy", r), 72'(busy), 72'(tbl[r].e_busy));
      chk($sformatf("t%0d_done", r), 72'(done), 72'(tbl[r].e_done));
      chk($sformatf("t%0d_valids", r),
          72'({weight_q_valid, weight_k_valid, weight_v_valid}),
          72'({tbl[r].e_qv, tbl[r].e_kv, tbl[r].e_vv}));
      if (tbl[r].e_qv) chk($sformatf("t%0d_q", r), weight_q, mk(tbl[r].e_val));
      if (tbl[r].e_kv) chk($sformatf("t%0d_k", r), weight_k, mk(tbl[r].e_val));
      if (tbl[r].e_vv) chk($sformatf("t%0d_v", r), weight_v, mk(tbl[r].e_val));
      step();
    end
    start           = 1'b0;
    weight_in_valid = 1'b0;

    // Q->K boundary hold, K back-pressure, stray start during SEND_V
    done_cnt = 0;
    sb_next  = 1;
    sb_en    = 1;
    do_start();
    for (int n = 1; n <= 6; n++) push(n, 0, 10);
    weight_q_ready  = 1'b0;
    weight_in       = mk(7);
    weight_in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk("qhold_q_valid", 72'(weight_q_valid), 72'(1));
      chk("qhold_q_data", weight_q, mk(6));
      chk("qhold_k_valid", 72'(weight_k_valid), 72'(0));
      chk("qhold_in_ready", 72'(weight_in_ready), 72'(0));
      step();
    end
    weight_q_ready = 1'b1;
    #1;
    chk("qdrain_in_ready", 72'(weight_in_ready), 72'(1));
    step();
    weight_k_ready  = 1'b0;
    weight_in       = mk(8);
    weight_in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #2;
      chk("khold_k_valid", 72'(weight_k_valid), 72'(1));
      chk("khold_k_data", weight_k, mk(7));
      chk("khold_in_ready", 72'(weight_in_ready), 72'(0));
      chk("khold_qv_valid", 72'({weight_q_valid, weight_v_valid}), 72'(0));
      step();
    end
    weight_k_ready  = 1'b1;
    weight_in_valid = 1'b0;
    for (int n = 8; n <= NT; n++) begin
      if (n == 14) start = 1'b1;
      push(n, 0, 10);
      start = 1'b0;
    end
    wait_done(20);
    chk("seqA_tiles", 72'(sb_next), 72'(NT + 1));
    chk("seqA_done_once", 72'(done_cnt), 72'(1));
    chk("seqA_busy_after", 72'(busy), 72'(0));

    // asynchronous reset mid-SEND_K with tile 9 held
    sb_en = 0;
    do_start();
    for (int n = 1; n <= 9; n++) push(n, 0, 10);
    weight_k_ready = 1'b0;
    #1;
    chk("pre_rst_k_valid", 72'(weight_k_valid), 72'(1));
    chk("pre_rst_busy", 72'(busy), 72'(1));
    #1;
    rst = 1'b0;
    #1;
    chk("arst_valids", 72'({weight_q_valid, weight_k_valid, weight_v_valid}), 72'(0));
    chk("arst_busy", 72'(busy), 72'(0));
    chk("arst_done", 72'(done), 72'(0));
    chk("arst_in_ready", 72'(weight_in_ready), 72'(0));
    step();
    step();
    rst            = 1'b1;
    weight_k_ready = 1'b1;
    step();
    done_cnt = 0;
    sb_next  = 1;
    sb_en    = 1;
    do_start();
    push(1, 0, 10);
    chk("restart_q_valid", 72'(weight_q_valid), 72'(1));
    chk("restart_q_data", weight_q, mk(1));
    for (int n = 2; n <= NT; n++) push(n, 0, 10);
    wait_done(20);
    chk("seqB_tiles", 72'(sb_next), 72'(NT + 1));
    chk("seqB_done_once", 72'(done_cnt), 72'(1));

    // toggling valid with random readies
    done_cnt = 0;
    sb_next  = 1;
    do_start();
    for (int n = 1; n <= NT; n++) begin
      push(n, 1, 60);
      weight_q_ready = 1'($urandom_range(0, 1));
      weight_k_ready = 1'($urandom_range(0, 1));
      weight_v_ready = 1'($urandom_range(0, 1));
      step();
    end
    wait_done(20);
    chk("seqC_tiles", 72'(sb_next), 72'(NT + 1));
    chk("seqC_done_once", 72'(done_cnt), 72'(1));
    sb_en = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
